// File: rtl/ucie_sb_tx_serializer_if.sv
// Packet handshake between the sideband encoder and the TX serializer.
interface ucie_sb_tx_serializer_if #(
  parameter int unsigned PKT_W = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ucie_sb_tx_serializer.sv
// UCIe sideband TX serializer: 2-deep packet buffer, LSB-first shifter with
// gated source-synchronous clock, and a fixed idle gap after every packet.
module ucie_sb_tx_serializer #(
  parameter int unsigned PKT_W    = 64,
  parameter int unsigned HALF_PER = 1,
  parameter int unsigned GAP_UI   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  ucie_sb_tx_serializer_if.slave   sb_in,
  output logic                     SBTX_CLK,
  output logic                     SBTX_DATA,
  output logic                     busy,
  output logic                     pkt_sent
);

  localparam int unsigned PH_W    = $clog2(HALF_PER) + 1;
  localparam int unsigned BIT_W   = $clog2(PKT_W);
  localparam int unsigned GAP_CYC = GAP_UI * 2 * HALF_PER;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [PKT_W-1:0]   r_mem [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic [PKT_W-1:0]   r_shift;
  logic [PH_W-1:0]    r_ph;
  logic               r_high;
  logic [BIT_W-1:0]   r_bit;
  logic [GAP_W-1:0]   r_gap;

  logic               w_push;
  logic               w_pop;
  logic               w_gap_done;
  logic [1:0]         w_count_nxt;
  logic [PKT_W-1:0]   w_head;

  // Ready is combinational so it drops in the same cycle reset is asserted.
  assign sb_in.in_ready = (r_count < 2'd2) && reset;

  assign w_push      = sb_in.in_valid && sb_in.in_ready;
  assign w_gap_done  = (r_state == S_GAP) && (r_gap == GAP_W'(GAP_CYC - 1));
  assign w_pop       = (r_count != 2'd0) && ((r_state == S_IDLE) || w_gap_done);
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
  assign w_head      = r_mem[r_rptr];

  // Buffer storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= sb_in.in_data;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= w_count_nxt;
    end
  end

  // Serializer FSM: UI = low phase then high phase; data changes only as a UI begins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_ph      <= '0;
      r_high    <= 1'b0;
      r_bit     <= '0;
      r_gap     <= '0;
      SBTX_CLK  <= 1'b0;
      SBTX_DATA <= 1'b0;
      busy      <= 1'b0;
      pkt_sent  <= 1'b0;
    end else begin
      pkt_sent <= 1'b0;
      busy     <= 1'b1;
      case (r_state)
        S_IDLE: begin
          SBTX_CLK <= 1'b0;
          if (w_pop) begin
            r_shift   <= w_head;
            SBTX_DATA <= w_head[0];
            r_bit     <= '0;
            r_ph      <= '0;
            r_high    <= 1'b0;
            r_state   <= S_SHIFT;
          end else begin
            SBTX_DATA <= 1'b0;
            busy      <= (w_count_nxt != 2'd0);
          end
        end
        S_SHIFT: begin
          if (r_ph == PH_W'(HALF_PER - 1)) begin
            r_ph <= '0;
            if (!r_high) begin
              r_high   <= 1'b1;
              SBTX_CLK <= 1'b1;
            end else begin
              r_high   <= 1'b0;
              SBTX_CLK <= 1'b0;
              if (r_bit == BIT_W'(PKT_W - 1)) begin
                pkt_sent  <= 1'b1;
                SBTX_DATA <= 1'b0;
                r_gap     <= '0;
                r_state   <= S_GAP;
              end else begin
                r_bit     <= r_bit + BIT_W'(1);
                r_shift   <= r_shift >> 1;
                SBTX_DATA <= r_shift[1];
              end
            end
          end else begin
            r_ph <= r_ph + PH_W'(1);
          end
        end
        S_GAP: begin
          SBTX_CLK  <= 1'b0;
          SBTX_DATA <= 1'b0;
          if (w_gap_done) begin
            if (w_pop) begin
              r_shift   <= w_head;
              SBTX_DATA <= w_head[0];
              r_bit     <= '0;
              r_ph      <= '0;
              r_high    <= 1'b0;
              r_state   <= S_SHIFT;
            end else begin
              busy    <= (w_count_nxt != 2'd0);
              r_state <= S_IDLE;
            end
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: begin
          SBTX_CLK  <= 1'b0;
          SBTX_DATA <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucie_sb_tx_serializer.sv
// Directed bench for the sideband TX serializer: two instances (default timing
// and HALF_PER=3/GAP_UI=4) driven from one sequential stimulus thread.
module tb_ucie_sb_tx_serializer;

  logic clk;
  logic rst;
  logic sbclk0, sbdat0, busy0, ps0;
  logic sbclk1, sbdat1, busy1, ps1;

  ucie_sb_tx_serializer_if #(.PKT_W(64)) if0 ();
  ucie_sb_tx_serializer_if #(.PKT_W(64)) if1 ();

  ucie_sb_tx_serializer #(.PKT_W(64), .HALF_PER(1), .GAP_UI(32)) dut0 (
    .clk(clk), .reset(rst), .sb_in(if0),
    .SBTX_CLK(sbclk0), .SBTX_DATA(sbdat0), .busy(busy0), .pkt_sent(ps0)
  );

  ucie_sb_tx_serializer #(.PKT_W(64), .HALF_PER(3), .GAP_UI(4)) dut1 (
    .clk(clk), .reset(rst), .sb_in(if1),
    .SBTX_CLK(sbclk1), .SBTX_DATA(sbdat1), .busy(busy1), .pkt_sent(ps1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  int   r0_t[$];
  logic r0_d[$];
  int   p0_q[$];
  int   r1_t[$];
  int   p1_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and record SBTX_CLK rises (with data) and pkt_sent pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sbclk0 && !prev0) begin
      r0_t.push_back(cyc);
      r0_d.push_back(sbdat0);
    end
    prev0 = sbclk0;
    if (ps0) p0_q.push_back(cyc);
    if (sbclk1 && !prev1) r1_t.push_back(cyc);
    prev1 = sbclk1;
    if (ps1) p1_q.push_back(cyc);
  endtask

  task automatic clear();
    r0_t.delete();
    r0_d.delete();
    p0_q.delete();
    r1_t.delete();
    p1_q.delete();
  endtask

  function automatic logic [63:0] rebuild(input int base);
    logic [63:0] rx;
    rx = '0;
    for (int i = 0; i < 64; i++) begin
      if (base + i < r0_d.size()) rx[i] = r0_d[base + i];
    end
    return rx;
  endfunction

  function automatic int rise0(input int idx);
    return (idx < r0_t.size()) ? r0_t[idx] : -1;
  endfunction

  function automatic int sent0(input int idx);
    return (idx < p0_q.size()) ? p0_q[idx] : -1;
  endfunction

  int e0, t, cnt, rdy_t;
  logic b_a, b_b;
  logic [11:0] clkpat, datpat;

  initial begin
    rst = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    repeat (3) step();
    chk("rst_clk",   64'(sbclk0), 64'(0));
    chk("rst_data",  64'(sbdat0), 64'(0));
    chk("rst_busy",  64'(busy0), 64'(0));
    chk("rst_sent",  64'(ps0), 64'(0));
    chk("rst_ready", 64'(if0.in_ready), 64'(0));
    rst = 1'b1;
    step();
    chk("rel_ready", 64'(if0.in_ready), 64'(1));
    repeat (3) step();

    // Single packet, H=1
    clear();
    if0.in_data = 64'h0123_4567_89AB_CDEF; if0.in_valid = 1'b1;
    step(); e0 = cyc; if0.in_valid = 1'b0;
    chk("t1_busy_push", 64'(busy0), 64'(1));
    chk("t1_data_e0", 64'(sbdat0), 64'(0));
    step();
    chk("t1_bit0_first", 64'({sbclk0, sbdat0}), 64'(2'b01));
    cnt = 0; b_a = 1'b0; b_b = 1'b1;
    repeat (200) begin
      step(); t = cyc - e0;
      if (t >= 129 && t <= 192 && (sbclk0 || sbdat0)) cnt++;
      if (t == 192) b_a = busy0;
      if (t == 193) b_b = busy0;
    end
    chk("t1_rises", 64'(r0_t.size()), 64'(64));
    chk("t1_data", rebuild(0), 64'h0123_4567_89AB_CDEF);
    chk("t1_first_rise", 64'(rise0(0) - e0), 64'(2));
    chk("t1_sent_n", 64'(p0_q.size()), 64'(1));
    chk("t1_sent_t", 64'(sent0(0) - e0), 64'(129));
    chk("t1_gap_quiet", 64'(cnt), 64'(0));
    chk("t1_busy_gap_end", 64'(b_a), 64'(1));
    chk("t1_busy_fall", 64'(b_b), 64'(0));

    // Three packets back to back
    clear();
    if0.in_data = 64'hA5A5_0000_FFFF_1234; if0.in_valid = 1'b1;
    step(); e0 = cyc;
    chk("t2_ready_a", 64'(if0.in_ready), 64'(1));
    if0.in_data = 64'h8000_0000_0000_0001;
    step();
    chk("t2_ready_b", 64'(if0.in_ready), 64'(1));
    if0.in_data = 64'h7FFF_FFFF_FFFF_FFFE;
    step(); if0.in_valid = 1'b0;
    chk("t2_ready_full", 64'(if0.in_ready), 64'(0));
    rdy_t = -1;
    for (int i = 0; i < 400 && rdy_t < 0; i++) begin
      step();
      if (if0.in_ready) rdy_t = cyc - e0;
    end
    chk("t2_ready_return", 64'(rdy_t), 64'(193));
    while (cyc - e0 < 590) step();
    chk("t2_rises", 64'(r0_t.size()), 64'(192));
    chk("t2_sent_n", 64'(p0_q.size()), 64'(3));
    chk("t2_first_rise", 64'(rise0(0) - e0), 64'(2));
    chk("t2_period_ab", 64'(rise0(64) - rise0(0)), 64'(192));
    chk("t2_period_bc", 64'(rise0(128) - rise0(64)), 64'(192));
    chk("t2_data_a", rebuild(0), 64'hA5A5_0000_FFFF_1234);
    chk("t2_data_b", rebuild(64), 64'h8000_0000_0000_0001);
    chk("t2_data_c", rebuild(128), 64'h7FFF_FFFF_FFFF_FFFE);

    // H=3, GAP_UI=4 on the second instance
    clear();
    if1.in_data = 64'h1; if1.in_valid = 1'b1;
    step(); e0 = cyc; if1.in_valid = 1'b0;
    clkpat = '0; datpat = '0; cnt = 0; b_a = 1'b0; b_b = 1'b1; rdy_t = 0;
    repeat (420) begin
      step(); t = cyc - e0;
      if (t >= 1 && t <= 12) begin
        clkpat[t-1] = sbclk1;
        datpat[t-1] = sbdat1;
      end
      if (sbdat1) cnt++;
      if (t >= 385 && t <= 408 && (sbclk1 || sbdat1)) rdy_t++;
      if (t == 408) b_a = busy1;
      if (t == 409) b_b = busy1;
    end
    chk("t3_clk_pattern", 64'(clkpat), 64'(12'hE38));
    chk("t3_data_pattern", 64'(datpat), 64'(12'h03F));
    chk("t3_data_high_cycles", 64'(cnt), 64'(6));
    chk("t3_rises", 64'(r1_t.size()), 64'(64));
    chk("t3_sent_n", 64'(p1_q.size()), 64'(1));
    chk("t3_sent_t", 64'((p1_q.size() > 0 ? p1_q[0] : -1) - e0), 64'(385));
    chk("t3_gap_quiet", 64'(rdy_t), 64'(0));
    chk("t3_busy_gap_end", 64'(b_a), 64'(1));
    chk("t3_busy_fall", 64'(b_b), 64'(0));

    // Reset in the middle of bit 20 with a second packet queued
    clear();
    if0.in_data = 64'hFFFF_FFFF_FFFF_FFFF; if0.in_valid = 1'b1;
    step(); e0 = cyc;
    if0.in_data = 64'h5555_5555_5555_5555;
    step(); if0.in_valid = 1'b0;
    while (cyc - e0 < 42) step();
    chk("t4_bit20_data", 64'(sbdat0), 64'(1));
    chk("t4_rises_pre", 64'(r0_t.size()), 64'(21));
    rst = 1'b0;
    step();
    chk("t4_rst_clk", 64'(sbclk0), 64'(0));
    chk("t4_rst_data", 64'(sbdat0), 64'(0));
    chk("t4_rst_busy", 64'(busy0), 64'(0));
    chk("t4_rst_sent", 64'(ps0), 64'(0));
    chk("t4_rst_ready", 64'(if0.in_ready), 64'(0));
    rst = 1'b1;
    step();
    chk("t4_rel_ready", 64'(if0.in_ready), 64'(1));
    chk("t4_rel_busy", 64'(busy0), 64'(0));
    repeat (300) step();
    chk("t4_no_more_rises", 64'(r0_t.size()), 64'(21));
    chk("t4_no_sent", 64'(p0_q.size()), 64'(0));
    chk("t4_idle_busy", 64'(busy0), 64'(0));

    // All-zero packet
    clear();
    if0.in_data = 64'h0; if0.in_valid = 1'b1;
    step(); e0 = cyc; if0.in_valid = 1'b0;
    cnt = 0;
    repeat (200) begin
      step();
      if (sbdat0) cnt++;
    end
    chk("t5_rises", 64'(r0_t.size()), 64'(64));
    chk("t5_data_high", 64'(cnt), 64'(0));
    chk("t5_sent_n", 64'(p0_q.size()), 64'(1));
    chk("t5_sent_t", 64'(sent0(0) - e0), 64'(129));

    // Push landing on the gap-expiry edge with an empty buffer
    clear();
    if0.in_data = 64'h0000_0000_0000_00A5; if0.in_valid = 1'b1;
    step(); e0 = cyc; if0.in_valid = 1'b0;
    cnt = 0; b_a = 1'b0;
    while (cyc - e0 < 400) begin
      step(); t = cyc - e0;
      if (t >= 129 && t <= 194 && sbclk0) cnt++;
      if (t == 193) b_a = busy0;
      if (t == 192) begin
        if0.in_data = 64'hC3C3_0F0F_F0F0_3C3C; if0.in_valid = 1'b1;
      end else begin
        if0.in_valid = 1'b0;
      end
    end
    chk("t6_rises", 64'(r0_t.size()), 64'(128));
    chk("t6_last_rise_a", 64'(rise0(63) - e0), 64'(128));
    chk("t6_first_rise_b", 64'(rise0(64) - e0), 64'(195));
    chk("t6_no_glitch", 64'(cnt), 64'(0));
    chk("t6_busy_expiry", 64'(b_a), 64'(1));
    chk("t6_sent_b_t", 64'(sent0(1) - e0), 64'(322));
    chk("t6_data_a", rebuild(0), 64'h0000_0000_0000_00A5);
    chk("t6_data_b", rebuild(64), 64'hC3C3_0F0F_F0F0_3C3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ucie_sb_tx_serializer.md
# ucie_sb_tx_serializer

Transmit-side serializer for the UCIe sideband link. It accepts 64-bit sideband packets over a valid/ready handshake and buffers up to two of them. It shifts each packet out LSB-first on SBTX_DATA with a gated, source-synchronous SBTX_CLK, then enforces the mandatory idle gap between packets. It sits between the sideband packet encoder and the SBTX pins, and is the counterpart of the sideband receive path that samples SBRX_CLK/SBRX_DATA.

## Interface
Parameters:
- PKT_W, 64: packet width in bits (UI per packet).
- HALF_PER, 1: clk cycles per SBTX_CLK half-period; one UI = 2*HALF_PER clk cycles; must be >= 1.
- GAP_UI, 32: idle UI (clock and data low) after each packet; must be >= 1.

Ports:
- clk  input  1  single block clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  packet offered.
- in_ready  output  1  buffer can accept a packet.
- in_data  input  PKT_W  packet; bit 0 is transmitted first.
- SBTX_CLK  output  1  gated sideband TX clock, registered.
- SBTX_DATA  output  1  sideband TX serial data, registered.
- busy  output  1  buffer non-empty or state != IDLE.
- pkt_sent  output  1  one-cycle pulse when the last bit's UI completes.

## Operation
- Input buffer: 2-entry FIFO.
  - Push on in_valid && in_ready.
  - in_ready = (count < 2) && reset deasserted.
  - Push and pop in the same cycle are legal; count is unchanged.
  - in_data is ignored when in_valid is low.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: SBTX_CLK=0, SBTX_DATA=0. On any edge with FIFO count > 0: pop the head into the shift register, drive bit 0, go to SHIFT.
  - SHIFT: each UI has a low phase (SBTX_CLK=0, HALF_PER cycles) then a high phase (SBTX_CLK=1, HALF_PER cycles).
    - SBTX_DATA changes only at the start of a low phase, so it is stable across every SBTX_CLK rising edge (receiver samples on rise).
    - A 6-bit bit counter (log2 PKT_W) advances at the end of each UI.
    - After UI PKT_W-1 completes: pulse pkt_sent, drive SBTX_CLK=0 and SBTX_DATA=0, go to GAP.
  - GAP: SBTX_CLK and SBTX_DATA are held 0 for GAP_UI*2*HALF_PER cycles. On the edge where the gap counter expires:
    - FIFO non-empty: pop and go directly to SHIFT with bit 0 driven.
    - FIFO empty: go to IDLE.
- SBTX_CLK is 0 in IDLE and GAP. It toggles only in SHIFT, giving exactly PKT_W rising edges per packet.
- Counter widths: phase counter log2(HALF_PER)+1 bits; gap counter sized for GAP_UI*2*HALF_PER. No wrap is reachable.
- Reset (reset==0 at a clk edge), including mid-packet or mid-gap:
  - State goes to IDLE and the FIFO is flushed. The in-flight packet is dropped, with no pkt_sent.
  - Outputs after the edge: SBTX_CLK=0, SBTX_DATA=0, busy=0, pkt_sent=0.
  - in_ready=0 while reset is low; in_ready=1 on the first cycle after release.

## Timing
- Let E0 be the handshake edge into an empty FIFO while IDLE. The pop happens at E0+1, and bit 0 appears on SBTX_DATA after E0+1.
- Bit k is driven for cycles [E0+1+2kH, E0+1+2(k+1)H), where H=HALF_PER.
- SBTX_CLK rises at E0+1+(2k+1)H.
- pkt_sent is high for the single cycle after edge E0+1+2*PKT_W*H, which is the same edge GAP is entered.
- Back-to-back packet period is exactly (PKT_W+GAP_UI)*2*H cycles; default H=1 gives 192 cycles.
- busy deasserts on the cycle after the GAP to IDLE transition.
- A push in the same cycle that GAP expires with an otherwise empty FIFO does not start at that edge. It starts at the next edge through IDLE, one cycle later.

## Test plan
- Single packet, H=1, in_data=64'h0123_4567_89AB_CDEF:
  - Capture SBTX_DATA on each SBTX_CLK rise; require exactly 64 rises reconstructing 64'h0123_4567_89AB_CDEF LSB-first.
  - Bit 0 appears 1 cycle after the handshake.
  - pkt_sent pulses once, 128 cycles after the first bit.
  - Clock and data then stay low for 64 cycles; busy falls afterwards.
- Three packets offered on consecutive cycles (A, B, C):
  - A pops at once; B and C fill the FIFO and in_ready drops.
  - in_ready returns when B pops, 192 cycles after A starts.
  - Rising-edge spacing between packet starts is exactly 192 cycles.
  - The received order is A, B, C.
- H=3, GAP_UI=4, packet 64'h1:
  - SBTX_CLK has 3 low then 3 high cycles per UI.
  - Data is 1 for the first 6 cycles, then 0.
  - The gap lasts 24 cycles.
- Reset asserted for 1 cycle at bit 20 of packet 64'hFFFF_FFFF_FFFF_FFFF with a second packet queued:
  - SBTX_CLK and SBTX_DATA are 0 the next cycle.
  - No pkt_sent; busy=0; FIFO is empty (the queued packet is never sent).
  - in_ready=1 on the first cycle after release.
- All-zero packet: still exactly 64 SBTX_CLK rises with SBTX_DATA=0 throughout, and pkt_sent pulses once.
- Push arriving on the same edge the GAP expires with the FIFO empty: the packet starts 1 cycle later via IDLE, and there is no SBTX_CLK glitch in between.
